// File: rtl/sprite_line_buffer_if.sv
// sprite_line_buffer_if: renderer write port and raster scan-out port of the sprite line buffer.
//   cen        pixel clock enable (never high on two consecutive clocks)
//   line_start one-clock pulse (qualified by cen) that swaps the draw/scan banks
//   wr_valid / wr_ready / wr_x / wr_pix   renderer pixel write handshake
//   rd_x       scan-out raster X position
//   col        registered scan-out code {transparent, colour}
//   init_busy  high during the post-reset clear sweep
//   overrun    one-clock pulse: a pending write was not accepted at a bank swap
// master: renderer/video side, slave: line buffer.
interface sprite_line_buffer_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned PW = 4
);
  logic          cen;
  logic          line_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [XW-1:0] wr_x;
  logic [PW-1:0] wr_pix;
  logic [XW-1:0] rd_x;
  logic [PW:0]   col;
  logic          init_busy;
  logic          overrun;

  modport master (
    output cen, line_start, wr_valid, wr_x, wr_pix, rd_x,
    input  wr_ready, col, init_busy, overrun
  );

  modport slave (
    input  cen, line_start, wr_valid, wr_x, wr_pix, rd_x,
    output wr_ready, col, init_busy, overrun
  );
endinterface

// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: double-banked sprite line buffer.
// The renderer writes pixels into the draw bank (wsel) while the scan bank (~wsel) is read out
// on each cen and cleared one clock later. Banks swap on cen & line_start.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         sprite_line_buffer_if.slave (write handshake, scan-out, status)
// Build option: define LBUF_LAST_WINS_EN to write non-transparent pixels unconditionally
// (later sprite overwrites); by default the first non-transparent write to a location wins.
module sprite_line_buffer #(
  parameter int unsigned XW = 8,
  parameter int unsigned PW = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  sprite_line_buffer_if.slave bus
);

  localparam int unsigned Depth = 2 ** XW;

  typedef enum logic [1:0] {StInit, StIdle, StRd, StWr} state_e;

  state_e        state_q, state_d;
  logic          wsel_q, wsel_d;
  logic [XW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] lat_x_q, lat_x_d;
  logic [PW-1:0] lat_pix_q, lat_pix_d;
  logic          lat_bank_q, lat_bank_d;
  logic [PW:0]   col_q, col_d;
  logic          clr_pend_q, clr_pend_d;
  logic [XW-1:0] clr_x_q, clr_x_d;
  logic          clr_bank_q, clr_bank_d;
`ifndef LBUF_LAST_WINS_EN
  logic [PW-1:0] rd_data_q, rd_data_d;
`endif

  logic [PW-1:0] mem [2][Depth];

  logic          wr_en;
  logic          wr_ready;
  logic          overrun;
  logic          swap;
  logic          scan_rd;
  logic          clr_hit;
  logic [PW-1:0] scan_data;

  always_comb begin
    state_d    = state_q;
    wsel_d     = wsel_q;
    cnt_d      = cnt_q;
    lat_x_d    = lat_x_q;
    lat_pix_d  = lat_pix_q;
    lat_bank_d = lat_bank_q;
    col_d      = col_q;
    clr_pend_d = 1'b0;
    clr_x_d    = clr_x_q;
    clr_bank_d = clr_bank_q;
`ifndef LBUF_LAST_WINS_EN
    rd_data_d  = rd_data_q;
`endif
    wr_en      = 1'b0;
    wr_ready   = 1'b0;
    swap       = bus.cen & bus.line_start & (state_q != StInit);
    scan_rd    = bus.cen & (state_q != StInit);
    scan_data  = mem[~wsel_q][bus.rd_x];
    // A pending clear on the writer's bank owns the write port this cycle.
    clr_hit    = clr_pend_q & (clr_bank_q == lat_bank_q);

    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StIdle;
      end
      StIdle: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          lat_x_d    = bus.wr_x;
          lat_pix_d  = bus.wr_pix;
          lat_bank_d = wsel_q;
          // Transparent pixels are dropped at acceptance.
          if (bus.wr_pix != '0) begin
`ifdef LBUF_LAST_WINS_EN
            state_d = StWr;
`else
            state_d = StRd;
`endif
          end
        end
      end
`ifndef LBUF_LAST_WINS_EN
      StRd: begin
        rd_data_d = mem[lat_bank_q][lat_x_q];
        state_d   = StWr;
      end
`endif
      StWr: begin
        if (clr_hit && (clr_x_q == lat_x_q)) begin
          // Clear wins a same-address collision; the pixel is lost.
          state_d = StIdle;
        end else if (!clr_hit) begin
`ifdef LBUF_LAST_WINS_EN
          wr_en = 1'b1;
`else
          wr_en = (rd_data_q == '0);
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    if (swap) wsel_d = ~wsel_q;
    overrun = swap & bus.wr_valid & ~wr_ready;

    // Read uses the pre-swap scan bank; clear that same location next clock.
    if (scan_rd) begin
      col_d      = {(scan_data == '0), scan_data};
      clr_pend_d = 1'b1;
      clr_x_d    = bus.rd_x;
      clr_bank_d = ~wsel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      wsel_q     <= 1'b0;
      cnt_q      <= '0;
      lat_x_q    <= '0;
      lat_pix_q  <= '0;
      lat_bank_q <= 1'b0;
      col_q      <= {1'b1, {PW{1'b0}}};
      clr_pend_q <= 1'b0;
      clr_x_q    <= '0;
      clr_bank_q <= 1'b0;
`ifndef LBUF_LAST_WINS_EN
      rd_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wsel_q     <= wsel_d;
      cnt_q      <= cnt_d;
      lat_x_q    <= lat_x_d;
      lat_pix_q  <= lat_pix_d;
      lat_bank_q <= lat_bank_d;
      col_q      <= col_d;
      clr_pend_q <= clr_pend_d;
      clr_x_q    <= clr_x_d;
      clr_bank_q <= clr_bank_d;
`ifndef LBUF_LAST_WINS_EN
      rd_data_q  <= rd_data_d;
`endif
    end
  end

  // Storage has no reset; the INIT sweep clears both banks.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[0][cnt_q] <= '0;
      mem[1][cnt_q] <= '0;
    end else begin
      if (clr_pend_q) mem[clr_bank_q][clr_x_q] <= '0;
      if (wr_en) mem[lat_bank_q][lat_x_q] <= lat_pix_q;
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.col       = col_q;
  assign bus.init_busy = (state_q == StInit);
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// tb_sprite_line_buffer: directed self-checking bench for sprite_line_buffer.
module tb_sprite_line_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sprite_line_buffer_if #(.XW(8), .PW(4)) bus ();

  sprite_line_buffer #(.XW(8), .PW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LBUF_LAST_WINS_EN
  localparam logic [4:0] PrioExp   = 5'h09;
  localparam int         BusyCyc   = 1;
`else
  localparam logic [4:0] PrioExp   = 5'h03;
  localparam int         BusyCyc   = 2;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cen        = 1'b0;
    bus.line_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_x       = 8'h00;
    bus.wr_pix     = 4'h0;
    bus.rd_x       = 8'hFF;
  endtask

  task automatic scan(input logic [7:0] x, output logic [4:0] c);
    bus.rd_x = x;
    bus.cen  = 1'b1;
    tick();
    c        = bus.col;
    bus.cen  = 1'b0;
    bus.rd_x = 8'hFF;
    tick();
  endtask

  task automatic swap();
    bus.rd_x       = 8'hFF;
    bus.cen        = 1'b1;
    bus.line_start = 1'b1;
    tick();
    bus.cen        = 1'b0;
    bus.line_start = 1'b0;
    tick();
  endtask

  task automatic write_pix(input logic [7:0] x, input logic [3:0] p);
    int n;
    n            = 0;
    bus.wr_valid = 1'b1;
    bus.wr_x     = x;
    bus.wr_pix   = p;
    while (bus.wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL write_accept_timeout: x=%h waited %0d cycles, limit 20", x, n);
    end
    tick();
    bus.wr_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Counts clocks from reset release until init_busy drops; checks wr_ready stays low.
  task automatic run_init(input string tag);
    int n;
    bit rdy_bad;
    n       = 0;
    rdy_bad = 1'b0;
    rst_n   = 1'b1;
    while (bus.init_busy === 1'b1 && n < 400) begin
      if (bus.wr_ready !== 1'b0) rdy_bad = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL %s_init_len: busy for %0d clocks, want 256", tag, n);
    end
    checks++;
    if (rdy_bad) begin
      errors++;
      $display("FAIL %s_init_ready: wr_ready high during sweep, want 0", tag);
    end
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after_init: got %b want 1", tag, bus.wr_ready);
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    logic [4:0] c;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.col !== 5'h10) begin
      errors++;
      $display("FAIL reset_col: got %h want 10", bus.col);
    end
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", bus.wr_ready);
    end
    checks++;
    if (bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b want 1", bus.init_busy);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    end
    // Let the sweep run a while, then pulse a swap with a pending write: must be ignored.
    rst_n = 1'b1;
    repeat (100) tick();
    bus.cen        = 1'b1;
    bus.line_start = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_pix     = 4'h1;
    #1;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL init_overrun: got %b want 0", bus.overrun);
    end
    tick();
    idle_inputs();
    n = 101;
    while (bus.init_busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL first_init_len: busy for %0d clocks, want 256", n);
    end
    bad = 0;
    for (int x = 0; x < 256; x++) begin
      scan(8'(x), c);
      if (c !== 5'h10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_scan_all: %0d locations not 10, want 0", bad);
    end
  endtask

  task automatic test_write_scan();
    logic [4:0] c;
    write_pix(8'h10, 4'h5);
    swap();
    scan(8'h10, c);
    checks++;
    if (c !== 5'h05) begin
      errors++;
      $display("FAIL write_scan: got %h want 05", c);
    end
    swap();
    swap();
    scan(8'h10, c);
    checks++;
    if (c !== 5'h10) begin
      errors++;
      $display("FAIL clear_after_read: got %h want 10", c);
    end
  endtask

  task automatic test_priority();
    int n;
    logic [4:0] c;
    bus.wr_valid = 1'b1;
    bus.wr_x     = 8'h20;
    bus.wr_pix   = 4'h3;
    tick();
    bus.wr_valid = 1'b0;
    n = 0;
    while (bus.wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != BusyCyc) begin
      errors++;
      $display("FAIL pixel_busy_cycles: got %0d want %0d", n, BusyCyc);
    end
    write_pix(8'h20, 4'h9);
    swap();
    scan(8'h20, c);
    checks++;
    if (c !== PrioExp) begin
      errors++;
      $display("FAIL priority: got %h want %h", c, PrioExp);
    end
  endtask

  task automatic test_transparent();
    logic [4:0] c;
    bit bad;
    bad          = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_x     = 8'h30;
    bus.wr_pix   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wr_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL transparent_ready: wr_ready dropped=%b now=%b want 0/1", bad, bus.wr_ready);
    end
    bus.wr_valid = 1'b0;
    swap();
    scan(8'h30, c);
    checks++;
    if (c !== 5'h10) begin
      errors++;
      $display("FAIL transparent_scan: got %h want 10", c);
    end
  endtask

  task automatic test_overrun();
    int n;
    logic [4:0] c;
    bus.wr_valid = 1'b1;
    bus.wr_x     = 8'h40;
    bus.wr_pix   = 4'h7;
    tick();
    // Pixel in flight; next pixel waits while the banks swap.
    bus.wr_x       = 8'h41;
    bus.wr_pix     = 4'h6;
    bus.rd_x       = 8'hFF;
    bus.cen        = 1'b1;
    bus.line_start = 1'b1;
    #1;
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %b want 1", bus.overrun);
    end
    tick();
    bus.cen        = 1'b0;
    bus.line_start = 1'b0;
    #1;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_single: got %b want 0", bus.overrun);
    end
    n = 0;
    while (bus.wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL overrun_accept_timeout: waited %0d cycles, limit 20", n);
    end
    tick();
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    scan(8'h40, c);
    checks++;
    if (c !== 5'h07) begin
      errors++;
      $display("FAIL overrun_old_bank: got %h want 07", c);
    end
    scan(8'h41, c);
    checks++;
    if (c !== 5'h10) begin
      errors++;
      $display("FAIL overrun_new_bank: got %h want 10", c);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] c;
    write_pix(8'h60, 4'hB);
    write_pix(8'h50, 4'hA);
    swap();
    scan(8'h50, c);
    checks++;
    if (c !== 5'h0A) begin
      errors++;
      $display("FAIL mid_pre_scan: got %h want 0a", c);
    end
    bus.wr_valid = 1'b1;
    bus.wr_x     = 8'h70;
    bus.wr_pix   = 4'hC;
    tick();
    bus.wr_valid = 1'b0;
`ifndef LBUF_LAST_WINS_EN
    tick();
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.col !== 5'h10) begin
      errors++;
      $display("FAIL mid_reset_col: got %h want 10", bus.col);
    end
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_status: ready=%b busy=%b want 0/1", bus.wr_ready, bus.init_busy);
    end
    repeat (2) tick();
    run_init("mid");
    swap();
    scan(8'h60, c);
    checks++;
    if (c !== 5'h10) begin
      errors++;
      $display("FAIL mid_sweep_cleared: got %h want 10", c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_write_scan();
    test_priority();
    test_transparent();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
